ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- Execute/memory pipeline latch that sits directly downstream of the decode/execute latch, plus the data-memory access sequencer for the memory stage.
- Captures execute results and control, then issues exactly one dmem read or write per captured load/store.
- Holds the stage and raises a stall until the cache returns dhit.
- Presents load data and latched control to the memory/writeback latch.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous active-high reset
- en  in  1  advance latch (from hazard unit)
- flush  in  1  insert bubble (from hazard unit)
- instr_i, npc_i, curr_pc_i  in  32 each  instruction / next PC / current PC from execute
- aluout_i  in  32  ALU result, also dmem address
- store_i  in  32  store data (forwarded rdat2)
- regWr_i, dWEN_i, dREN_i, halt_i  in  1 each  control from execute
- rdSel_i  in  3  writeback source select
- dhit  in  1  dmem access complete this cycle
- dmemload  in  32  dmem read data, valid when dhit
- dmemREN, dmemWEN  out  1 each  dmem request strobes
- dmemaddr, dmemstore  out  32 each  dmem address / store data
- instr_o, npc_o, curr_pc_o, aluout_o  out  32 each  latched fields
- regWr_o, halt_o  out  1 each  latched control
- rdSel_o  out  3  latched select
- rdata_o  out  32  load data for the memory/writeback latch
- mem_busy  out  1  stall request to hazard unit
- stall_cnt  out  CNT_W  cycles spent with mem_busy=1

Behaviour:
- Reset (RST=1 at posedge):
  - all latched outputs, load register and stall_cnt go to 0.
  - FSM goes to IDLE.
  - dmemREN=dmemWEN=0.
  - RST has priority over everything and aborts any in-flight request.
- Internal latch also holds dWEN_q, dREN_q, store_q. These are not exported except through the dmem ports.
- FSM states:
  - IDLE: no access pending.
  - REQ: access outstanding.
  - DONE: access finished; latch still holds that instruction.
- Request strobes:
  - dmemREN = (state==REQ) & dREN_q
  - dmemWEN = (state==REQ) & dWEN_q
  - dmemaddr = aluout_o and dmemstore = store_q at all times.
- mem_busy = (state==REQ) & ~dhit. This is combinational, so the latch may advance in the same cycle dhit arrives.
- Priority at posedge, when not in reset:
  1. flush & ~mem_busy: all latched fields go to 0 (bubble) and state goes to IDLE.
  2. en & ~mem_busy: capture all *_i. State goes to REQ if dREN_i|dWEN_i, else IDLE.
  3. Otherwise hold all fields.
  - en and flush are ignored while mem_busy=1. An outstanding access is never abandoned or re-issued.
- Completion:
  - In REQ with dhit=1 and no capture, state goes to DONE.
  - If dREN_q, the load register takes dmemload.
  - DONE never re-requests. It leaves only via capture or flush.
- rdata_o:
  - = dmemload when state==REQ & dhit.
  - else = load register.
  - The load register updates on dhit even when a new instruction is captured the same cycle.
- Store-then-load back-to-back: the store completes (dhit) and the load is captured in the same cycle. dmemREN asserts the next cycle with no idle gap.
- dREN_i and dWEN_i both 1 is illegal upstream. The block issues both strobes with no checking.
- stall_cnt increments by 1 each cycle mem_busy=1. It saturates at all-ones and does not wrap.
- A halt instruction is latched like any other field. The block takes no special action; halt_o propagates downstream.

Test Plan:
1. RST held 2 cycles mid-REQ (dhit=0) → next cycle: all outputs 0, dmemREN=0, mem_busy=0, stall_cnt=0.
2. Capture load (dREN_i=1, aluout_i=0x0000_0100, en=1), dhit after 3 cycles with dmemload=0xDEAD_BEEF:
   - dmemREN=1 and dmemaddr=0x100 for 3 cycles; mem_busy=1 for 2 cycles then 0 in the dhit cycle.
   - rdata_o=0xDEADBEEF; stall_cnt=2.
   - dmemREN=0 thereafter (DONE).
3. Store (dWEN_i=1, store_i=0x1234_5678, addr 0x200), en held high, dhit on cycle 2 with the next instruction being a load to 0x200:
   - dmemWEN=1 for 2 cycles.
   - load captured on the dhit edge; dmemREN=1 and addr 0x200 the following cycle.
4. flush=1 and en=1 asserted while in REQ with dhit=0 → fields unchanged, dmemREN stays 1. On the dhit cycle with flush=1 → bubble captured (instr_o=0, regWr_o=0), state IDLE.
5. ALU-only instruction (dREN_i=dWEN_i=0, aluout_i=0x42, regWr_i=1) → no dmem strobes, mem_busy never asserts, aluout_o=0x42 one cycle after en.
6. Force stall_cnt near max (CNT_W=4 build) with a 20-cycle miss → stall_cnt holds at 0xF.

Source files
------------

// File: rtl/ex_mem.sv
// ex_mem: execute/memory pipeline latch plus data-memory access sequencer.
//
// Captures execute-stage results and control when the hazard unit advances
// the pipe, issues exactly one dmem read or write for every captured
// load/store, and holds the stage (mem_busy) until the cache reports dhit.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   en, flush           advance / bubble requests from the hazard unit
//   instr_i .. rdSel_i  execute-stage fields and control
//   dhit, dmemload      dmem completion and read data
//   dmemREN/WEN/addr/store  dmem request interface
//   instr_o .. rdSel_o  latched fields for the memory/writeback latch
//   rdata_o             load data (bypasses dmemload in the dhit cycle)
//   mem_busy            stall request to the hazard unit
//   stall_cnt           saturating count of cycles with mem_busy=1
//   state_o             FSM state for debug (0=IDLE, 1=REQ, 2=DONE)
//
// Handshake: a dmem request is held on dmemREN/dmemWEN from the cycle after
// capture until the cycle dhit=1; that cycle completes it. The stage never
// drops or re-issues an outstanding request, so en/flush are ignored while
// mem_busy=1.
module ex_mem #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      npc_i,
  input  logic [31:0]      curr_pc_i,
  input  logic [31:0]      aluout_i,
  input  logic [31:0]      store_i,
  input  logic             regWr_i,
  input  logic             dWEN_i,
  input  logic             dREN_i,
  input  logic             halt_i,
  input  logic [2:0]       rdSel_i,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      instr_o,
  output logic [31:0]      npc_o,
  output logic [31:0]      curr_pc_o,
  output logic [31:0]      aluout_o,
  output logic             regWr_o,
  output logic             halt_o,
  output logic [2:0]       rdSel_o,
  output logic [31:0]      rdata_o,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [31:0]      instr_q, npc_q, curr_pc_q, aluout_q, store_q, load_q;
  logic             regWr_q, halt_q, dWEN_q, dREN_q;
  logic [2:0]       rdSel_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             in_req;

  assign in_req   = (state_q == REQ);
  // Combinational so the latch can advance in the very cycle dhit arrives.
  assign mem_busy = in_req & ~dhit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      npc_q       <= '0;
      curr_pc_q   <= '0;
      aluout_q    <= '0;
      store_q     <= '0;
      load_q      <= '0;
      regWr_q     <= 1'b0;
      halt_q      <= 1'b0;
      dWEN_q      <= 1'b0;
      dREN_q      <= 1'b0;
      rdSel_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush & ~mem_busy) begin
        // Bubble: clear every latched field so nothing downstream acts.
        state_q   <= IDLE;
        instr_q   <= '0;
        npc_q     <= '0;
        curr_pc_q <= '0;
        aluout_q  <= '0;
        store_q   <= '0;
        regWr_q   <= 1'b0;
        halt_q    <= 1'b0;
        dWEN_q    <= 1'b0;
        dREN_q    <= 1'b0;
        rdSel_q   <= '0;
      end else if (en & ~mem_busy) begin
        state_q   <= (dREN_i | dWEN_i) ? REQ : IDLE;
        instr_q   <= instr_i;
        npc_q     <= npc_i;
        curr_pc_q <= curr_pc_i;
        aluout_q  <= aluout_i;
        store_q   <= store_i;
        regWr_q   <= regWr_i;
        halt_q    <= halt_i;
        dWEN_q    <= dWEN_i;
        dREN_q    <= dREN_i;
        rdSel_q   <= rdSel_i;
      end else if (in_req & dhit) begin
        // Finished but not yet replaced: park in DONE so no re-request.
        state_q <= DONE;
      end

      // Keep the returned word even if a new instruction is captured now.
      if (in_req & dhit & dREN_q) begin
        load_q <= dmemload;
      end

      if (mem_busy && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign dmemREN   = in_req & dREN_q;
  assign dmemWEN   = in_req & dWEN_q;
  assign dmemaddr  = aluout_q;
  assign dmemstore = store_q;

  assign instr_o   = instr_q;
  assign npc_o     = npc_q;
  assign curr_pc_o = curr_pc_q;
  assign aluout_o  = aluout_q;
  assign regWr_o   = regWr_q;
  assign halt_o    = halt_q;
  assign rdSel_o   = rdSel_q;
  assign rdata_o   = (in_req & dhit) ? dmemload : load_q;
  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, en, flush, dhit;
  logic [31:0] instr_i, npc_i, curr_pc_i, aluout_i, store_i, dmemload;
  logic        regWr_i, dWEN_i, dREN_i, halt_i;
  logic [2:0]  rdSel_i;

  logic        dmemREN, dmemWEN, regWr_o, halt_o, mem_busy;
  logic [31:0] dmemaddr, dmemstore, instr_o, npc_o, curr_pc_o, aluout_o, rdata_o;
  logic [2:0]  rdSel_o;
  logic [31:0] stall_cnt;
  logic [1:0]  state_o;

  // Narrow-counter instance shares all inputs; only its counter is of interest.
  logic        s_dmemREN, s_dmemWEN, s_regWr_o, s_halt_o, s_mem_busy;
  logic [31:0] s_dmemaddr, s_dmemstore, s_instr_o, s_npc_o, s_curr_pc_o, s_aluout_o, s_rdata_o;
  logic [2:0]  s_rdSel_o;
  logic [3:0]  s_stall_cnt;
  logic [1:0]  s_state_o;

  ex_mem #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .instr_i(instr_i), .npc_i(npc_i), .curr_pc_i(curr_pc_i), .aluout_i(aluout_i),
    .store_i(store_i), .regWr_i(regWr_i), .dWEN_i(dWEN_i), .dREN_i(dREN_i),
    .halt_i(halt_i), .rdSel_i(rdSel_i), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .instr_o(instr_o), .npc_o(npc_o), .curr_pc_o(curr_pc_o), .aluout_o(aluout_o),
    .regWr_o(regWr_o), .halt_o(halt_o), .rdSel_o(rdSel_o), .rdata_o(rdata_o),
    .mem_busy(mem_busy), .stall_cnt(stall_cnt), .state_o(state_o)
  );

  ex_mem #(.CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .instr_i(instr_i), .npc_i(npc_i), .curr_pc_i(curr_pc_i), .aluout_i(aluout_i),
    .store_i(store_i), .regWr_i(regWr_i), .dWEN_i(dWEN_i), .dREN_i(dREN_i),
    .halt_i(halt_i), .rdSel_i(rdSel_i), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN), .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore),
    .instr_o(s_instr_o), .npc_o(s_npc_o), .curr_pc_o(s_curr_pc_o), .aluout_o(s_aluout_o),
    .regWr_o(s_regWr_o), .halt_o(s_halt_o), .rdSel_o(s_rdSel_o), .rdata_o(s_rdata_o),
    .mem_busy(s_mem_busy), .stall_cnt(s_stall_cnt), .state_o(s_state_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is either carrying an outstanding access or not; once an
  // access finishes the instruction simply sits there until replaced.
  logic        m_pend;
  logic [31:0] m_instr, m_npc, m_pc, m_alu, m_store, m_load;
  logic        m_regwr, m_halt, m_dwen, m_dren;
  logic [2:0]  m_rdsel;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt_s;

  task automatic m_clear_fields();
    m_instr = 0; m_npc = 0; m_pc = 0; m_alu = 0; m_store = 0;
    m_regwr = 0; m_halt = 0; m_dwen = 0; m_dren = 0; m_rdsel = 0;
    m_pend  = 0;
  endtask

  initial begin
    m_clear_fields();
    m_load = 0; m_cnt = 0; m_cnt_s = 0;
  end

  always @(posedge CLK) begin
    logic stalled;
    stalled = m_pend && !dhit;
    if (RST) begin
      m_clear_fields();
      m_load = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (stalled) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 1;
      end
      if (m_pend && dhit && m_dren) m_load = dmemload;
      if (!stalled && flush) begin
        m_clear_fields();
      end else if (!stalled && en) begin
        m_instr = instr_i; m_npc = npc_i; m_pc = curr_pc_i; m_alu = aluout_i;
        m_store = store_i; m_regwr = regWr_i; m_halt = halt_i;
        m_dwen = dWEN_i; m_dren = dREN_i; m_rdsel = rdSel_i;
        m_pend = dREN_i | dWEN_i;
      end else if (m_pend && dhit) begin
        m_pend = 0;
      end
    end
  end

  // Single compare process: every cycle, mid-cycle, against the model.
  always @(negedge CLK) begin
    if (check_en) begin
      chk("dmemREN",   32'(dmemREN),   32'(m_pend & m_dren));
      chk("dmemWEN",   32'(dmemWEN),   32'(m_pend & m_dwen));
      chk("dmemaddr",  dmemaddr,  m_alu);
      chk("dmemstore", dmemstore, m_store);
      chk("instr_o",   instr_o,   m_instr);
      chk("npc_o",     npc_o,     m_npc);
      chk("curr_pc_o", curr_pc_o, m_pc);
      chk("aluout_o",  aluout_o,  m_alu);
      chk("regWr_o",   32'(regWr_o), 32'(m_regwr));
      chk("halt_o",    32'(halt_o),  32'(m_halt));
      chk("rdSel_o",   32'(rdSel_o), 32'(m_rdsel));
      chk("rdata_o",   rdata_o, (m_pend && dhit) ? dmemload : m_load);
      chk("mem_busy",  32'(mem_busy), 32'(m_pend & ~dhit));
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("stall_cnt_w4", 32'(s_stall_cnt), 32'(m_cnt_s));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic mid();  // move to just after the negedge of the current cycle
    #4;
  endtask

  task automatic idle_inputs();
    en = 0; flush = 0; dhit = 0; dmemload = 0;
    instr_i = 0; npc_i = 0; curr_pc_i = 0; aluout_i = 0; store_i = 0;
    regWr_i = 0; dWEN_i = 0; dREN_i = 0; halt_i = 0; rdSel_i = 0;
  endtask

  task automatic put_instr(input logic [31:0] instr, input logic [31:0] alu,
                           input logic [31:0] st, input logic ren, input logic wen,
                           input logic rw, input logic [2:0] sel);
    en = 1; instr_i = instr; aluout_i = alu; store_i = st;
    dREN_i = ren; dWEN_i = wen; regWr_i = rw; rdSel_i = sel;
    npc_i = instr + 32'h4; curr_pc_i = instr;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    RST = 1;
    tick(); tick();
    check_en = 1;
    RST = 0;

    // 1: reset aborts a request in flight
    put_instr(32'h0000_1000, 32'h0000_0080, 32'h0, 1, 0, 1, 3'd1);
    tick();
    en = 0; dhit = 0;
    tick();
    RST = 1;
    tick(); tick();
    RST = 0;
    mid();
    chk("t1_dmemREN", 32'(dmemREN), 32'd0);
    chk("t1_busy", 32'(mem_busy), 32'd0);
    chk("t1_cnt", stall_cnt, 32'd0);
    chk("t1_instr", instr_o, 32'd0);
    tick();

    // 2: load with dhit on the third request cycle
    put_instr(32'h0000_2000, 32'h0000_0100, 32'h0, 1, 0, 1, 3'd2);
    tick();
    idle_inputs();
    mid();
    chk("t2_ren_c1", 32'(dmemREN), 32'd1);
    chk("t2_addr", dmemaddr, 32'h0000_0100);
    chk("t2_busy_c1", 32'(mem_busy), 32'd1);
    tick(); tick();
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    mid();
    chk("t2_busy_hit", 32'(mem_busy), 32'd0);
    chk("t2_rdata_hit", rdata_o, 32'hDEAD_BEEF);
    tick();
    dhit = 0; dmemload = 32'h0;
    mid();
    chk("t2_ren_done", 32'(dmemREN), 32'd0);
    chk("t2_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("t2_cnt", stall_cnt, 32'd2);
    tick();

    // 3: store then back-to-back load, en held high
    put_instr(32'h0000_3000, 32'h0000_0200, 32'h1234_5678, 0, 1, 0, 3'd0);
    tick();
    put_instr(32'h0000_3004, 32'h0000_0200, 32'h0, 1, 0, 1, 3'd2);
    mid();
    chk("t3_wen_c1", 32'(dmemWEN), 32'd1);
    chk("t3_store", dmemstore, 32'h1234_5678);
    tick();
    dhit = 1;
    mid();
    chk("t3_wen_c2", 32'(dmemWEN), 32'd1);
    tick();
    idle_inputs();
    mid();
    chk("t3_ren_next", 32'(dmemREN), 32'd1);
    chk("t3_addr_next", dmemaddr, 32'h0000_0200);
    chk("t3_instr_next", instr_o, 32'h0000_3004);
    tick();
    dhit = 1; dmemload = 32'hCAFE_F00D;
    tick();
    idle_inputs();

    // 4: flush/en ignored while busy, bubble on the dhit cycle
    put_instr(32'h0000_4000, 32'h0000_0300, 32'h0, 1, 0, 1, 3'd2);
    tick();
    put_instr(32'h0000_5555, 32'h0000_0555, 32'h0, 0, 0, 1, 3'd3);
    flush = 1;
    tick();
    mid();
    chk("t4_instr_held", instr_o, 32'h0000_4000);
    chk("t4_ren_held", 32'(dmemREN), 32'd1);
    dhit = 1; dmemload = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    mid();
    chk("t4_bubble_instr", instr_o, 32'd0);
    chk("t4_bubble_regwr", 32'(regWr_o), 32'd0);
    chk("t4_ren_idle", 32'(dmemREN), 32'd0);
    tick();

    // 5: ALU-only instruction, with halt riding along
    put_instr(32'h0000_6000, 32'h0000_0042, 32'h0, 0, 0, 1, 3'd0);
    halt_i = 1;
    tick();
    idle_inputs();
    mid();
    chk("t5_alu", aluout_o, 32'h0000_0042);
    chk("t5_regwr", 32'(regWr_o), 32'd1);
    chk("t5_halt", 32'(halt_o), 32'd1);
    chk("t5_busy", 32'(mem_busy), 32'd0);
    chk("t5_strobes", {30'd0, dmemREN, dmemWEN}, 32'd0);
    tick();

    // 6: 20-cycle miss saturates the 4-bit counter (2+2+1 stalls so far)
    put_instr(32'h0000_7000, 32'h0000_0700, 32'h0, 1, 0, 1, 3'd2);
    tick();
    idle_inputs();
    for (int i = 0; i < 20; i++) tick();
    dhit = 1; dmemload = 32'h7777_7777;
    mid();
    chk("t6_cnt_w4_sat", 32'(s_stall_cnt), 32'h0000_000F);
    chk("t6_cnt_w32", stall_cnt, 32'd25);
    tick();
    idle_inputs();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
